calc_sequencer: RTL and testbench

Sequencer between the keypad decoder and the arithmetic datapath of the calculator. It consumes decoded key codes over a valid/ack handshake and builds signed decimal operands. It issues add/sub/mul jobs to the multi-cycle ALU over a start/done handshake, then presents the result on `display_output` with a `complete` flag. It owns all operand/operator state; the keypad scanner and the ALU are stateless with respect to the expression.

---
 rtl/calc_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds signed decimal operands from keypad codes,
// issues jobs to the multi-cycle ALU and presents the result with status flags.
module calc_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_read,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_ovf,
  output logic [15:0] display_output,
  output logic        complete,
  output logic        error
);

  localparam int unsigned CW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, ISSUE, WAIT_ALU, SHOW} state_t;

  state_t        state, state_n;
  logic [14:0]   mag, mag_n;
  logic          neg, neg_n;
  logic          has_digit, has_digit_n;
  logic [15:0]   a_q, a_n, b_q, b_n, disp_n;
  logic [1:0]    op_q, op_n;
  logic          complete_n, error_n, key_read_n;
  logic          key_wait, key_wait_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          is_digit, is_op, is_eq, is_clr, is_neg;
  logic [3:0]    digit;
  logic [1:0]    op_key;
  logic          accept;
  logic [14:0]   mag_base, bmag;
  logic          neg_base, has_base, bneg, bhas;
  logic [16:0]   dig_sum;
  logic          dig_ok;
  logic [15:0]   cur_val, new_val;

  function automatic logic [15:0] signed_val(input logic n, input logic [14:0] m);
    logic [15:0] e;
    e = {1'b0, m};
    return n ? (~e + 16'd1) : e;
  endfunction

  always_comb begin
    is_digit = 1'b0;
    is_op    = 1'b0;
    is_eq    = 1'b0;
    is_clr   = 1'b0;
    is_neg   = 1'b0;
    digit    = '0;
    op_key   = '0;
    case (key_code)
      4'd0, 4'd1, 4'd2:  begin is_digit = 1'b1; digit = key_code + 4'd1; end
      4'd4, 4'd5, 4'd6:  begin is_digit = 1'b1; digit = key_code;        end
      4'd8, 4'd9, 4'd10: begin is_digit = 1'b1; digit = key_code - 4'd1; end
      4'd13:             begin is_digit = 1'b1; digit = 4'd0;            end
      4'd3:              begin is_op = 1'b1; op_key = 2'b00; end
      4'd7:              begin is_op = 1'b1; op_key = 2'b01; end
      4'd11:             begin is_op = 1'b1; op_key = 2'b10; end
      4'd12:             is_eq  = 1'b1;
      4'd14:             is_clr = 1'b1;
      default:           is_neg = 1'b1;
    endcase
  end

  // A key in SHOW starts a fresh operand, so the builder starts from zero there.
  // Magnitudes above 3276 always overflow, which keeps the 17-bit sum from wrapping.
  always_comb begin
    mag_base = (state == SHOW) ? '0 : mag;
    neg_base = (state == SHOW) ? 1'b0 : neg;
    has_base = (state == SHOW) ? 1'b0 : has_digit;
    dig_sum  = 17'(mag_base) * 17'd10 + 17'(digit);
    dig_ok   = (mag_base <= 15'd3276) && (dig_sum <= 17'd32767);
    bmag     = mag_base;
    bneg     = neg_base;
    bhas     = has_base;
    if (is_digit && dig_ok) begin
      bmag = dig_sum[14:0];
      bhas = 1'b1;
    end
    if (is_neg && !has_base)
      bneg = ~neg_base;
    cur_val = signed_val(neg, mag);
    new_val = signed_val(bneg, bmag);
  end

  assign accept = key_valid && !key_wait &&
                  (state == ENTRY_A || state == ENTRY_B || state == SHOW);

  always_comb begin
    state_n     = state;
    mag_n       = mag;
    neg_n       = neg;
    has_digit_n = has_digit;
    a_n         = a_q;
    b_n         = b_q;
    op_n        = op_q;
    disp_n      = display_output;
    complete_n  = complete;
    error_n     = error;
    cnt_n       = cnt;
    key_read_n  = 1'b0;
    key_wait_n  = key_valid ? key_wait : 1'b0;

    if (accept) begin
      key_read_n = 1'b1;
      key_wait_n = 1'b1;
    end

    if (accept && is_clr) begin
      state_n     = ENTRY_A;
      mag_n       = '0;
      neg_n       = 1'b0;
      has_digit_n = 1'b0;
      a_n         = '0;
      b_n         = '0;
      op_n        = '0;
      disp_n      = '0;
      complete_n  = 1'b0;
      error_n     = 1'b0;
      cnt_n       = '0;
    end else begin
      case (state)
        ENTRY_A, ENTRY_B, SHOW: begin
          if (accept) begin
            if (is_digit || is_neg) begin
              mag_n       = bmag;
              neg_n       = bneg;
              has_digit_n = bhas;
              disp_n      = new_val;
              complete_n  = 1'b0;
              error_n     = 1'b0;
              if (state == SHOW)
                state_n = ENTRY_A;
            end else if (is_op) begin
              if (state == ENTRY_B) begin
                if (!has_digit && !neg)
                  op_n = op_key;
              end else begin
                a_n         = (state == SHOW) ? display_output : cur_val;
                op_n        = op_key;
                mag_n       = '0;
                neg_n       = 1'b0;
                has_digit_n = 1'b0;
                disp_n      = '0;
                complete_n  = 1'b0;
                error_n     = 1'b0;
                state_n     = ENTRY_B;
              end
            end else if (is_eq) begin
              if (state == ENTRY_A) begin
                a_n         = cur_val;
                disp_n      = cur_val;
                complete_n  = 1'b1;
                mag_n       = '0;
                neg_n       = 1'b0;
                has_digit_n = 1'b0;
                state_n     = SHOW;
              end else if (state == ENTRY_B) begin
                b_n         = cur_val;
                mag_n       = '0;
                neg_n       = 1'b0;
                has_digit_n = 1'b0;
                state_n     = ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          cnt_n   = CW'(1);
          state_n = WAIT_ALU;
        end
        WAIT_ALU: begin
          if (alu_done) begin
            disp_n     = alu_result;
            error_n    = alu_ovf;
            complete_n = 1'b1;
            state_n    = SHOW;
          end else if (cnt == CW'(ALU_TIMEOUT - 1)) begin
            disp_n     = '0;
            error_n    = 1'b1;
            complete_n = 1'b1;
            state_n    = SHOW;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = ENTRY_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state          <= ENTRY_A;
      mag            <= '0;
      neg            <= 1'b0;
      has_digit      <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      display_output <= '0;
      complete       <= 1'b0;
      error          <= 1'b0;
      cnt            <= '0;
      key_read       <= 1'b0;
      key_wait       <= 1'b0;
    end else begin
      state          <= state_n;
      mag            <= mag_n;
      neg            <= neg_n;
      has_digit      <= has_digit_n;
      a_q            <= a_n;
      b_q            <= b_n;
      op_q           <= op_n;
      display_output <= disp_n;
      complete       <= complete_n;
      error          <= error_n;
      cnt            <= cnt_n;
      key_read       <= key_read_n;
      key_wait       <= key_wait_n;
    end
  end

  assign alu_start = (state == ISSUE);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer. Key codes: digits 1-9 = 0,1,2,4,5,6,8,9,A,
// 0 = D, ADD 3, SUB 7, MUL B, EQ C, CLR E, NEG F. Vector keys are packed MSB-first.
module tb_calc_sequencer;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        key_read;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_ovf = 1'b0;
  logic [15:0] display_output;
  logic        complete, error;

  int compared = 0;
  int mismatched = 0;

  calc_sequencer #(.ALU_TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .key_valid(key_valid), .key_code(key_code),
    .key_read(key_read), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .display_output(display_output), .complete(complete), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] keys;
    bit          use_alu;
    logic [1:0]  op;
    logic [15:0] a, b, res;
    logic        ovf;
    logic [15:0] disp;
    logic        cmp, err;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    bit got;
    got = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (key_read) begin
        got = 1'b1;
        break;
      end
    end
    key_valid = 1'b0;
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL key_ack: no key_read for code %h within 50 cycles", code);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] k;
    k = v.keys;
    for (int i = 0; i < v.n; i++) begin
      press(k[31:28]);
      k = k << 4;
    end
    if (v.use_alu) begin
      chk({v.name, ".alu_start"}, 16'(alu_start), 16'd1);
      chk({v.name, ".alu_op"}, 16'(alu_op), 16'(v.op));
      chk({v.name, ".alu_a"}, alu_a, v.a);
      chk({v.name, ".alu_b"}, alu_b, v.b);
      @(negedge clk);
      chk({v.name, ".complete_wait"}, 16'(complete), 16'd0);
      alu_done   = 1'b1;
      alu_result = v.res;
      alu_ovf    = v.ovf;
      @(negedge clk);
      alu_done = 1'b0;
      alu_ovf  = 1'b0;
    end else begin
      chk({v.name, ".alu_start"}, 16'(alu_start), 16'd0);
    end
    chk({v.name, ".display"}, display_output, v.disp);
    chk({v.name, ".complete"}, 16'(complete), 16'(v.cmp));
    chk({v.name, ".error"}, 16'(error), 16'(v.err));
  endtask

  function automatic vec_t mk(input string nm, input int n, input logic [31:0] keys,
                              input bit use_alu, input logic [1:0] op,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] res, input logic ovf,
                              input logic [15:0] disp, input logic cmp, input logic err);
    vec_t v;
    v.name = nm; v.n = n; v.keys = keys; v.use_alu = use_alu; v.op = op;
    v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.disp = disp; v.cmp = cmp; v.err = err;
    return v;
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, ".display"}, display_output, 16'h0000);
    chk({nm, ".complete"}, 16'(complete), 16'd0);
    chk({nm, ".error"}, 16'(error), 16'd0);
    chk({nm, ".alu_start"}, 16'(alu_start), 16'd0);
    chk({nm, ".alu_op"}, 16'(alu_op), 16'd0);
    chk({nm, ".alu_a"}, alu_a, 16'h0000);
    chk({nm, ".alu_b"}, alu_b, 16'h0000);
    chk({nm, ".key_read"}, 16'(key_read), 16'd0);
  endtask

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk("neg_mul",    7, 32'hEF2BF4C0, 1, 2'b10, 16'hFFFD, 16'hFFFC, 16'h000C, 0, 16'h000C, 1, 0);
    tbl[1]  = mk("sub",        5, 32'hE574C000, 1, 2'b01, 16'h0005, 16'h0004, 16'h0001, 0, 16'h0001, 1, 0);
    tbl[2]  = mk("op_replace", 6, 32'hEA731C00, 1, 2'b00, 16'h0009, 16'h0002, 16'h000B, 0, 16'h000B, 1, 0);
    tbl[3]  = mk("ovf",        5, 32'hE132C000, 1, 2'b00, 16'h0002, 16'h0003, 16'h8000, 1, 16'h8000, 1, 1);
    tbl[4]  = mk("digits4000", 6, 32'hE4DDDD00, 0, 0, 0, 0, 0, 0, 16'h0FA0, 0, 0);
    tbl[5]  = mk("neg_late",   3, 32'hE2F00000, 0, 0, 0, 0, 0, 0, 16'h0003, 0, 0);
    tbl[6]  = mk("neg_first",  3, 32'hEF800000, 0, 0, 0, 0, 0, 0, 16'hFFF9, 0, 0);
    tbl[7]  = mk("max_pos",    6, 32'hE2186800, 0, 0, 0, 0, 0, 0, 16'h7FFF, 0, 0);
    tbl[8]  = mk("over_max",   6, 32'hE2186900, 0, 0, 0, 0, 0, 0, 16'h0CCC, 0, 0);
    tbl[9]  = mk("max_neg",    7, 32'hEF218680, 0, 0, 0, 0, 0, 0, 16'h8001, 0, 0);
    tbl[10] = mk("eq_in_a",    3, 32'hE9C00000, 0, 0, 0, 0, 0, 0, 16'h0008, 1, 0);
    tbl[11] = mk("wide_ovf",   7, 32'hE020D950, 0, 0, 0, 0, 0, 0, 16'h3334, 0, 0);
    tbl[12] = mk("neg_sub",    6, 32'hEF574C00, 1, 2'b01, 16'hFFFB, 16'h0004, 16'hFFF7, 0, 16'hFFF7, 1, 0);
    tbl[13] = mk("clr_mid",    6, 32'hE234E600, 0, 0, 0, 0, 0, 0, 16'h0006, 0, 0);

    repeat (3) @(negedge clk);
    RST = 1'b0;
    check_all_zero("reset");

    foreach (tbl[i]) run_vec(tbl[i]);

    // Chaining from a shown result.
    run_vec(mk("chain1", 5, 32'hE234C000, 1, 2'b00, 16'h0003, 16'h0004, 16'h0007, 0, 16'h0007, 1, 0));
    run_vec(mk("chain2", 3, 32'h31C00000, 1, 2'b00, 16'h0007, 16'h0002, 16'h0009, 0, 16'h0009, 1, 0));

    // NEG in SHOW drops complete immediately, then builds a new expression.
    run_vec(mk("show1", 5, 32'hE574C000, 1, 2'b01, 16'h0005, 16'h0004, 16'h0001, 0, 16'h0001, 1, 0));
    press(4'hF);
    chk("show_neg.complete", 16'(complete), 16'd0);
    chk("show_neg.display", display_output, 16'h0000);
    run_vec(mk("show2", 4, 32'h574C0000, 1, 2'b01, 16'hFFFB, 16'h0004, 16'hFFF7, 0, 16'hFFF7, 1, 0));
    press(4'hC);
    chk("show_eq.complete", 16'(complete), 16'd1);
    chk("show_eq.display", display_output, 16'hFFF7);

    // alu_done and a new key in the same cycle.
    press(4'hE); press(4'h1); press(4'hB); press(4'h2); press(4'hC);
    chk("coll.alu_start", 16'(alu_start), 16'd1);
    @(negedge clk);
    alu_done = 1'b1; alu_result = 16'h0006;
    key_valid = 1'b1; key_code = 4'h5;
    @(negedge clk);
    alu_done = 1'b0;
    chk("coll.key_read_wait", 16'(key_read), 16'd0);
    chk("coll.display", display_output, 16'h0006);
    chk("coll.complete", 16'(complete), 16'd1);
    @(negedge clk);
    chk("coll.key_read_show", 16'(key_read), 16'd1);
    chk("coll.complete_drop", 16'(complete), 16'd0);
    chk("coll.display_new", display_output, 16'h0005);
    key_valid = 1'b0;

    // Timeout with no alu_done, then a late done.
    press(4'hE); press(4'h0); press(4'h3); press(4'h0); press(4'hC);
    chk("to.alu_start", 16'(alu_start), 16'd1);
    for (int i = 1; i <= int'(TO); i++) begin
      @(negedge clk);
      if (i == int'(TO) - 1) chk("to.complete_early", 16'(complete), 16'd0);
    end
    chk("to.complete", 16'(complete), 16'd1);
    chk("to.error", 16'(error), 16'd1);
    chk("to.display", display_output, 16'h0000);
    alu_done = 1'b1; alu_result = 16'h0005;
    @(negedge clk);
    alu_done = 1'b0;
    chk("to_late.display", display_output, 16'h0000);
    chk("to_late.error", 16'(error), 16'd1);
    chk("to_late.complete", 16'(complete), 16'd1);

    // Reset while waiting on the ALU.
    press(4'hE); press(4'h2); press(4'h3); press(4'h4); press(4'hC);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check_all_zero("rst_mid");
    alu_done = 1'b1; alu_result = 16'h0063;
    @(negedge clk);
    alu_done = 1'b0;
    chk("rst_late.complete", 16'(complete), 16'd0);
    chk("rst_late.display", display_output, 16'h0000);
    run_vec(mk("after_rst", 4, 32'h234C0000, 1, 2'b00, 16'h0003, 16'h0004, 16'h0007, 0, 16'h0007, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
